// File: rtl/mem_stall_ctrl.sv
// rtl/mem_stall_ctrl.sv - load/store stall controller bridging the datapath to a ready/err bus
module mem_stall_ctrl #(
  parameter int width   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [width-1:0] ALUResult,
  input  logic [width-1:0] WriteData,
  output logic             stall,
  output logic [width-1:0] ReadData,
  output logic             MemFault,
  output logic             bus_req,
  output logic             bus_we,
  output logic [width-1:0] bus_addr,
  output logic [width-1:0] bus_wdata,
  input  logic             bus_ready,
  input  logic             bus_err,
  input  logic [width-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam logic [7:0] last_cnt = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     next_state;
  logic [7:0] cnt;
  logic       fault;
  logic       both_q;

  logic access;
  logic aligned;
  logic accept;
  logic misalign;
  logic complete_ok;
  logic complete_err;
  logic timeout_hit;

  assign access  = MemRead | MemWrite;
  assign aligned = (ALUResult[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    stall        = 1'b0;
    accept       = 1'b0;
    misalign     = 1'b0;
    complete_ok  = 1'b0;
    complete_err = 1'b0;
    timeout_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          stall = 1'b1;
          if (aligned) begin
            accept     = 1'b1;
            next_state = WAIT;
          end else begin
            misalign   = 1'b1;
            next_state = DONE;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (bus_ready) begin
          next_state = DONE;
          if (bus_err) begin
            complete_err = 1'b1;
          end else begin
            complete_ok = 1'b1;
          end
        end else if (cnt == last_cnt) begin
          timeout_hit = 1'b1;
          next_state  = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Fault is only ever visible during the single DONE cycle of an access.
  assign MemFault = (state == DONE) && fault;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      ReadData  <= '0;
      cnt       <= '0;
      fault     <= 1'b0;
      both_q    <= 1'b0;
    end else begin
      bus_req <= (next_state == WAIT);
      if (accept) begin
        bus_addr  <= ALUResult;
        bus_wdata <= WriteData;
        bus_we    <= MemWrite;
        both_q    <= MemRead & MemWrite;
        cnt       <= '0;
        fault     <= 1'b0;
      end
      if (misalign) begin
        ReadData <= '0;
        fault    <= 1'b1;
      end
      // A store leaves ReadData alone unless it was a load/store collision.
      if (complete_ok) begin
        if (!bus_we) begin
          ReadData <= bus_rdata;
        end else if (both_q) begin
          ReadData <= '0;
        end
      end
      if (complete_err || timeout_hit) begin
        ReadData <= '0;
        fault    <= 1'b1;
      end
      if ((state == WAIT) && !bus_ready && !timeout_hit) begin
        cnt <= cnt + 8'd1;
      end
      if (state == DONE) begin
        fault <= 1'b0;
      end
    end
  end

endmodule
